fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the LC-3b pipeline. It owns the PC, issues requests to the I-cache, and loads the IF/ID pipeline register. On a flush pulse from the flush generator it redirects the PC, invalidates IF/ID, and discards any in-flight I-cache response so that no wrong-path instruction enters decode.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
stall  input  1  downstream hazard stall; IF/ID must hold.
flush  input  1  redirect request from flush generator; single-cycle pulse.
flush_target  input  16  redirect PC; bit 0 ignored.
icache_resp  input  1  I-cache data valid for the current request.
icache_rdata  input  16  instruction word, valid while icache_resp=1.
icache_read  output  1  request strobe.
icache_address  output  16  request address.
ifid_valid  output  1  IF/ID holds a real instruction.
ifid_pc  output  16  PC of ifid_instr.
ifid_pc_plus2  output  16  ifid_pc+2.
ifid_instr  output  16  fetched instruction.

Behaviour:
- Reset (async): pc=PC_RESET, state=FETCH, redirect_pc=0, skid=0, ifid_valid=0, ifid_pc=0, ifid_pc_plus2=0, ifid_instr=16'h0000 (NOP). icache_read=0 while rst=1.
- Cache protocol: icache_read and icache_address stay stable from assertion until the cycle icache_resp=1, inclusive. icache_resp may arrive in the first request cycle (hit) or later. One outstanding request at most.
- All PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000. flush_target[0] is forced to 0 when loaded.
- States: FETCH, DROP, HOLD.
- FETCH: icache_read=1, icache_address=pc.
  - flush & icache_resp: discard rdata; pc<=flush_target; ifid_valid<=0; stay FETCH.
  - flush & ~icache_resp: redirect_pc<=flush_target; ifid_valid<=0; go DROP. pc is unchanged so the address stays stable.
  - ~flush & icache_resp & ~stall: ifid_valid<=1, ifid_pc<=pc, ifid_pc_plus2<=pc+2, ifid_instr<=rdata; pc<=pc+2.
  - ~flush & icache_resp & stall: skid<=rdata; IF/ID holds; go HOLD.
  - ~flush & ~icache_resp: if ~stall then ifid_valid<=0 (bubble); if stall, IF/ID holds.
- DROP: icache_read=1, icache_address=pc (the old wrong-path address).
  - A new flush overwrites redirect_pc; the latest flush wins.
  - ifid_valid<=0 every cycle.
  - On icache_resp: discard rdata; pc<=redirect_pc (or flush_target if flush is in the same cycle); go FETCH.
- HOLD: icache_read=0.
  - flush: discard skid; pc<=flush_target; ifid_valid<=0; go FETCH.
  - ~stall: ifid_valid<=1, ifid_pc<=pc, ifid_pc_plus2<=pc+2, ifid_instr<=skid; pc<=pc+2; go FETCH.
  - stall: remain in HOLD; all state holds.
- flush overrides stall in every state: ifid_valid<=0 even when stall=1.
- Stall without flush: ifid_valid, ifid_pc, ifid_pc_plus2 and ifid_instr never change.
- Latency: on a hit, an instruction fetched at cycle N is visible on IF/ID at cycle N+1. After a flush, the first fetch at flush_target issues on the next cycle if no request is outstanding; otherwise it issues the cycle after the dropped response.
- Reset asserted mid-request or in DROP/HOLD returns to the reset state immediately. Any later icache_resp for the abandoned request is not re-requested.

Test Plan:
- Reset then hits every cycle with rdata=16'h1000+addr: ifid_pc steps 0000,0002,0004 with ifid_valid=1; icache_address increments by 2 per cycle.
- 3-cycle miss at pc=0x0010 with stall=0: ifid_valid=0 for 3 cycles, then ifid_instr=rdata and ifid_pc=0x0010; address stable throughout.
- flush (target 0x0400) during a miss at 0x0020, resp 2 cycles later: address stays 0x0020 until resp, rdata dropped, next request at 0x0400, ifid_valid=0 until the 0x0400 data arrives.
- Resp at 0x0030 while stall=1 for 3 cycles: icache_read=0 in HOLD, IF/ID unchanged; on stall release ifid_pc=0x0030 and the next request is at 0x0032.
- Two flushes in DROP (targets 0x0100, then 0x0200): fetch resumes at 0x0200. Flush in the same cycle as a hit: the hit data is discarded.
- pc=0xFFFE hit: ifid_pc_plus2=0x0000 and the next address is 0x0000. Assert rst mid-miss: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: LC-3b instruction fetch stage. Owns the PC, issues I-cache
// requests, loads IF/ID, and squashes wrong-path data on a flush.
module fetch_unit #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] flush_target,
  input  logic        icache_resp,
  input  logic [15:0] icache_rdata,
  output logic        icache_read,
  output logic [15:0] icache_address,
  output logic        ifid_valid,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc_plus2,
  output logic [15:0] ifid_instr
);

  localparam int unsigned XW = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [XW-1:0]   pc, pc_next;
  logic [XW-1:0]   redirect_pc, redirect_pc_next;
  logic [XW-1:0]   skid, skid_next;
  logic            ifid_valid_next;
  logic [XW-1:0]   ifid_pc_next, ifid_pc_plus2_next, ifid_instr_next;
  logic [XW-1:0]   target;
  logic [XW-1:0]   pc_plus2;

  // Redirect target is always halfword aligned; PC math wraps at 16 bits.
  assign target   = flush_target & 16'hFFFE;
  assign pc_plus2 = XW'(pc + 16'd2);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state logic: a flush during an outstanding miss waits out the
  // response in DROP; a response under stall parks in HOLD.
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (flush) begin
          if (!icache_resp) state_next = DROP;
        end else if (icache_resp && stall) begin
          state_next = HOLD;
        end
      end
      DROP: if (icache_resp) state_next = FETCH;
      HOLD: if (flush || !stall) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Output logic: request strobe is held through DROP so the old address
  // stays stable until its response retires.
  always_comb begin
    icache_read    = 1'b0;
    icache_address = pc;
    if (!rst && (state != HOLD)) icache_read = 1'b1;
  end

  // Datapath next values: PC, redirect, skid buffer and IF/ID.
  always_comb begin
    pc_next            = pc;
    redirect_pc_next   = redirect_pc;
    skid_next          = skid;
    ifid_valid_next    = ifid_valid;
    ifid_pc_next       = ifid_pc;
    ifid_pc_plus2_next = ifid_pc_plus2;
    ifid_instr_next    = ifid_instr;
    case (state)
      FETCH: begin
        if (flush) begin
          ifid_valid_next = 1'b0;
          if (icache_resp) pc_next = target;
          else             redirect_pc_next = target;
        end else if (icache_resp) begin
          if (!stall) begin
            ifid_valid_next    = 1'b1;
            ifid_pc_next       = pc;
            ifid_pc_plus2_next = pc_plus2;
            ifid_instr_next    = icache_rdata;
            pc_next            = pc_plus2;
          end else begin
            skid_next = icache_rdata;
          end
        end else if (!stall) begin
          ifid_valid_next = 1'b0;
        end
      end
      DROP: begin
        ifid_valid_next = 1'b0;
        if (flush) redirect_pc_next = target;
        if (icache_resp) pc_next = flush ? target : redirect_pc;
      end
      HOLD: begin
        if (flush) begin
          ifid_valid_next = 1'b0;
          pc_next         = target;
        end else if (!stall) begin
          ifid_valid_next    = 1'b1;
          ifid_pc_next       = pc;
          ifid_pc_plus2_next = pc_plus2;
          ifid_instr_next    = skid;
          pc_next            = pc_plus2;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= PC_RESET;
      redirect_pc   <= '0;
      skid          <= '0;
      ifid_valid    <= 1'b0;
      ifid_pc       <= '0;
      ifid_pc_plus2 <= '0;
      ifid_instr    <= 16'h0000;
    end else begin
      pc            <= pc_next;
      redirect_pc   <= redirect_pc_next;
      skid          <= skid_next;
      ifid_valid    <= ifid_valid_next;
      ifid_pc       <= ifid_pc_next;
      ifid_pc_plus2 <= ifid_pc_plus2_next;
      ifid_instr    <= ifid_instr_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit hits, misses, flushes,
// stalls, PC wrap and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] flush_target;
  logic        icache_resp;
  logic [15:0] icache_rdata;
  logic        icache_read;
  logic [15:0] icache_address;
  logic        ifid_valid;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus2;
  logic [15:0] ifid_instr;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.PC_RESET(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .flush_target   (flush_target),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus2  (ifid_pc_plus2),
    .ifid_instr     (ifid_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_target = 16'h0000;
    icache_resp = 1'b0; icache_rdata = 16'h0000;

    // Reset state
    #2;
    chk("rst_read",   16'(icache_read), 16'h0000);
    chk("rst_valid",  16'(ifid_valid),  16'h0000);
    chk("rst_pc",     ifid_pc,          16'h0000);
    chk("rst_pc2",    ifid_pc_plus2,    16'h0000);
    chk("rst_instr",  ifid_instr,       16'h0000);
    #10 rst = 1'b0;
    #1;
    chk("first_read", 16'(icache_read), 16'h0001);
    chk("first_addr", icache_address,   16'h0000);

    // Hits every cycle
    icache_resp = 1'b1; icache_rdata = 16'h1000;
    step();
    chk("hit0_valid", 16'(ifid_valid), 16'h0001);
    chk("hit0_pc",    ifid_pc,         16'h0000);
    chk("hit0_instr", ifid_instr,      16'h1000);
    chk("hit0_pc2",   ifid_pc_plus2,   16'h0002);
    chk("hit0_addr",  icache_address,  16'h0002);
    icache_rdata = 16'h1002;
    step();
    chk("hit1_pc",    ifid_pc,         16'h0002);
    chk("hit1_addr",  icache_address,  16'h0004);
    icache_rdata = 16'h1004;
    step();
    chk("hit2_pc",    ifid_pc,         16'h0004);
    chk("hit2_instr", ifid_instr,      16'h1004);
    chk("hit2_addr",  icache_address,  16'h0006);
    for (int i = 0; i < 5; i++) begin
      icache_rdata = 16'h1000 + icache_address;
      step();
    end
    chk("run_addr",   icache_address,  16'h0010);
    chk("run_pc",     ifid_pc,         16'h000E);

    // 3-cycle miss at 0x0010
    icache_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("miss_valid", 16'(ifid_valid), 16'h0000);
      chk("miss_addr",  icache_address,  16'h0010);
      chk("miss_read",  16'(icache_read), 16'h0001);
    end
    icache_resp = 1'b1; icache_rdata = 16'hABCD;
    step();
    chk("missd_valid", 16'(ifid_valid), 16'h0001);
    chk("missd_pc",    ifid_pc,         16'h0010);
    chk("missd_instr", ifid_instr,      16'hABCD);
    chk("missd_addr",  icache_address,  16'h0012);
    for (int i = 0; i < 7; i++) begin
      icache_rdata = 16'h1000 + icache_address;
      step();
    end
    chk("run2_addr",   icache_address,  16'h0020);

    // Flush during a miss at 0x0020, response two cycles later
    icache_resp = 1'b0; flush = 1'b1; flush_target = 16'h0400;
    step();
    chk("drop0_valid", 16'(ifid_valid), 16'h0000);
    chk("drop0_addr",  icache_address,  16'h0020);
    flush = 1'b0;
    step();
    chk("drop1_addr",  icache_address,  16'h0020);
    chk("drop1_read",  16'(icache_read), 16'h0001);
    icache_resp = 1'b1; icache_rdata = 16'hDEAD;
    step();
    chk("drop2_valid", 16'(ifid_valid), 16'h0000);
    chk("drop2_addr",  icache_address,  16'h0400);
    chk("drop2_instr", ifid_instr,      16'h101E);
    icache_resp = 1'b0;
    step();
    chk("tgt_miss_valid", 16'(ifid_valid), 16'h0000);
    icache_resp = 1'b1; icache_rdata = 16'h5555;
    step();
    chk("tgt_valid", 16'(ifid_valid), 16'h0001);
    chk("tgt_pc",    ifid_pc,         16'h0400);
    chk("tgt_instr", ifid_instr,      16'h5555);
    chk("tgt_addr",  icache_address,  16'h0402);

    // Flush in the same cycle as a hit; odd target bit 0 is dropped
    flush = 1'b1; flush_target = 16'h0031; icache_rdata = 16'h7777;
    step();
    chk("fhit_valid", 16'(ifid_valid), 16'h0000);
    chk("fhit_instr", ifid_instr,      16'h5555);
    chk("fhit_addr",  icache_address,  16'h0030);

    // Response at 0x0030 under a 3-cycle stall
    flush = 1'b0; stall = 1'b1; icache_rdata = 16'h3333;
    step();
    chk("hold0_read", 16'(icache_read), 16'h0000);
    chk("hold0_pc",   ifid_pc,          16'h0400);
    icache_resp = 1'b0; icache_rdata = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_read",  16'(icache_read), 16'h0000);
      chk("hold_instr", ifid_instr,       16'h5555);
      chk("hold_valid", 16'(ifid_valid),  16'h0000);
    end
    stall = 1'b0;
    step();
    chk("rel_valid", 16'(ifid_valid), 16'h0001);
    chk("rel_pc",    ifid_pc,         16'h0030);
    chk("rel_instr", ifid_instr,      16'h3333);
    chk("rel_pc2",   ifid_pc_plus2,   16'h0032);
    chk("rel_addr",  icache_address,  16'h0032);
    chk("rel_read",  16'(icache_read), 16'h0001);

    // Two flushes while in DROP; the later one wins
    flush = 1'b1; flush_target = 16'h0100;
    step();
    chk("dd0_addr", icache_address, 16'h0032);
    flush_target = 16'h0200;
    step();
    chk("dd1_addr",  icache_address,  16'h0032);
    chk("dd1_valid", 16'(ifid_valid), 16'h0000);
    flush = 1'b0; icache_resp = 1'b1; icache_rdata = 16'hBEEF;
    step();
    chk("dd2_addr",  icache_address,  16'h0200);
    chk("dd2_valid", 16'(ifid_valid), 16'h0000);
    icache_rdata = 16'h2222;
    step();
    chk("dd3_pc",    ifid_pc,    16'h0200);
    chk("dd3_instr", ifid_instr, 16'h2222);

    // PC wrap at 0xFFFE
    flush = 1'b1; flush_target = 16'hFFFE; icache_rdata = 16'h0BAD;
    step();
    chk("wrap0_addr", icache_address, 16'hFFFE);
    flush = 1'b0; icache_rdata = 16'h9999;
    step();
    chk("wrap_pc",   ifid_pc,        16'hFFFE);
    chk("wrap_pc2",  ifid_pc_plus2,  16'h0000);
    chk("wrap_addr", icache_address, 16'h0000);

    // Asynchronous reset in the middle of a miss
    icache_resp = 1'b0;
    step();
    chk("pre_rst_pc", ifid_pc, 16'hFFFE);
    #2 rst = 1'b1;
    #1;
    chk("arst_read",  16'(icache_read), 16'h0000);
    chk("arst_valid", 16'(ifid_valid),  16'h0000);
    chk("arst_pc",    ifid_pc,          16'h0000);
    chk("arst_pc2",   ifid_pc_plus2,    16'h0000);
    chk("arst_instr", ifid_instr,       16'h0000);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_addr", icache_address, 16'h0000);
    icache_resp = 1'b1; icache_rdata = 16'h4444;
    step();
    chk("post_rst_pc",    ifid_pc,    16'h0000);
    chk("post_rst_instr", ifid_instr, 16'h4444);
    chk("post_rst_addr2", icache_address, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
